// File: rtl/keypad_password_entry_pkg.sv
// Shared constants, keypad code map and scanner state type for the password-entry block.
package pw_pkg;

  localparam logic [4:0] EMPTY_DIGIT = 5'h1F;

  localparam logic [3:0] KEY_BKSP = 4'd10;
  localparam logic [3:0] KEY_CLR  = 4'd11;
  localparam logic [3:0] KEY_ENT  = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_E    = 4'd14;
  localparam logic [3:0] KEY_F    = 4'd15;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } scan_state_t;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = KEY_BKSP;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = KEY_CLR;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = KEY_ENT;
      4'hC:    code = KEY_E;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_F;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_password_entry_if.sv
// Keypad pins plus the digit fields and status pulses handed to the display and compare logic.
interface keypad_password_entry_if;

  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       lock;
  logic [4:0] p0;
  logic [4:0] p1;
  logic [4:0] p2;
  logic [4:0] p3;
  logic [4:0] p4;
  logic [4:0] p5;
  logic [2:0] digit_cnt;
  logic       show_digits;
  logic       submit;
  logic       reject;

  modport master (
    output key_row, lock,
    input  key_col, p0, p1, p2, p3, p4, p5, digit_cnt, show_digits, submit, reject
  );

  modport slave (
    input  key_row, lock,
    output key_col, p0, p1, p2, p3, p4, p5, digit_cnt, show_digits, submit, reject
  );

endinterface

// File: rtl/keypad_password_entry_scanner.sv
// Column scanner with tick divider, row synchroniser and press/release debounce.
// Emits a single-cycle key event with its code once a press has been stable long enough.
module keypad_password_entry_scanner
  import pw_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_keyRow,
  output logic [3:0] o_keyCol,
  output logic       o_keyEvt,
  output logic [3:0] o_keyCode
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);

  logic [TICK_W-1:0] r_tickCnt;
  logic [3:0]        r_rowMeta;
  logic [3:0]        r_rowSync;
  logic [DB_W-1:0]   r_dbCnt;
  logic [1:0]        r_colIdx;
  logic [1:0]        r_row;
  logic [3:0]        r_keyCol;
  logic              r_keyEvt;
  logic [3:0]        r_keyCode;
  scan_state_t       r_state;

  logic       w_tick;
  logic       w_anyLow;
  logic [1:0] w_lowRow;

  assign w_tick = (r_tickCnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tickCnt <= '0;
      r_rowMeta <= 4'hF;
      r_rowSync <= 4'hF;
    end else begin
      r_tickCnt <= w_tick ? '0 : r_tickCnt + TICK_W'(1);
      r_rowMeta <= i_keyRow;
      r_rowSync <= r_rowMeta;
    end
  end

  // Lowest-index low row wins when several keys in one column are down.
  always_comb begin
    w_anyLow = (r_rowSync != 4'hF);
    w_lowRow = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_rowSync[i]) w_lowRow = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_keyCol  <= 4'b1110;
      r_colIdx  <= 2'd0;
      r_row     <= 2'd0;
      r_dbCnt   <= '0;
      r_keyEvt  <= 1'b0;
      r_keyCode <= 4'd0;
    end else begin
      r_keyEvt <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_anyLow) begin
              r_row   <= w_lowRow;
              r_dbCnt <= '0;
              r_state <= ST_DEBOUNCE;
            end else begin
              r_keyCol <= {r_keyCol[2:0], r_keyCol[3]};
              r_colIdx <= r_colIdx + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (r_rowSync[r_row]) begin
              r_state <= ST_SCAN;
            end else if (r_dbCnt == DB_LAST) begin
              r_keyEvt  <= 1'b1;
              r_keyCode <= keymap(r_row, r_colIdx);
              r_dbCnt   <= '0;
              r_state   <= ST_HELD;
            end else begin
              r_dbCnt <= r_dbCnt + DB_W'(1);
            end
          end
          ST_HELD: begin
            if (w_anyLow) begin
              r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
              r_dbCnt <= '0;
              r_state <= ST_SCAN;
            end else begin
              r_dbCnt <= r_dbCnt + DB_W'(1);
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign o_keyCol  = r_keyCol;
  assign o_keyEvt  = r_keyEvt;
  assign o_keyCode = r_keyCode;

endmodule

// File: rtl/keypad_password_entry.sv
// Password entry: turns debounced key events into up to six digit fields plus edit,
// enter and show/mask handling for the password display and compare logic.
module keypad_password_entry
  import pw_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int MIN_LEN        = 4
) (
  input logic                    clk,
  input logic                    rst,
  keypad_password_entry_if.slave bus
);

  localparam logic [2:0] MIN_LEN_C = 3'(MIN_LEN);

  logic       w_keyEvt;
  logic [3:0] w_keyCode;
  logic       w_accept;

  logic [4:0] r_digits [6];
  logic [2:0] r_digitCnt;
  logic       r_show;
  logic       r_submit;
  logic       r_reject;
  logic       r_clearPending;

  keypad_password_entry_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .i_keyRow  (bus.key_row),
    .o_keyCol  (bus.key_col),
    .o_keyEvt  (w_keyEvt),
    .o_keyCode (w_keyCode)
  );

  assign w_accept = w_keyEvt && !bus.lock;

  // A submitted entry stays visible for the submit cycle and is wiped on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) r_digits[i] <= EMPTY_DIGIT;
      r_digitCnt     <= 3'd0;
      r_show         <= 1'b0;
      r_submit       <= 1'b0;
      r_reject       <= 1'b0;
      r_clearPending <= 1'b0;
    end else begin
      r_submit <= 1'b0;
      r_reject <= 1'b0;
      if (r_clearPending) begin
        for (int i = 0; i < 6; i++) r_digits[i] <= EMPTY_DIGIT;
        r_digitCnt     <= 3'd0;
        r_clearPending <= 1'b0;
      end else if (w_accept) begin
        if (w_keyCode <= 4'd9) begin
          if (r_digitCnt < 3'd6) begin
            r_digits[r_digitCnt] <= {1'b0, w_keyCode};
            r_digitCnt           <= r_digitCnt + 3'd1;
          end
        end else begin
          case (w_keyCode)
            KEY_BKSP: begin
              if (r_digitCnt != 3'd0) begin
                r_digits[r_digitCnt - 3'd1] <= EMPTY_DIGIT;
                r_digitCnt                  <= r_digitCnt - 3'd1;
              end
            end
            KEY_CLR: begin
              for (int i = 0; i < 6; i++) r_digits[i] <= EMPTY_DIGIT;
              r_digitCnt <= 3'd0;
            end
            KEY_ENT: begin
              if (r_digitCnt >= MIN_LEN_C) begin
                r_submit       <= 1'b1;
                r_clearPending <= 1'b1;
              end else begin
                r_reject <= 1'b1;
              end
            end
            KEY_F:   r_show <= ~r_show;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.p0          = r_digits[0];
  assign bus.p1          = r_digits[1];
  assign bus.p2          = r_digits[2];
  assign bus.p3          = r_digits[3];
  assign bus.p4          = r_digits[4];
  assign bus.p5          = r_digits[5];
  assign bus.digit_cnt   = r_digitCnt;
  assign bus.show_digits = r_show;
  assign bus.submit      = r_submit;
  assign bus.reject      = r_reject;

endmodule

// File: tb/tb_keypad_password_entry.sv
// Directed bench: a modelled 4x4 keypad matrix drives the entry block through digit,
// edit, enter, mask, lock, bounce and asynchronous reset scenarios.
module tb_keypad_password_entry;

  logic clk;
  logic rst;
  keypad_password_entry_if bus ();

  int checks = 0;
  int errors = 0;

  logic       keyDown;
  logic [1:0] keyR;
  logic [1:0] keyC;
  logic       bounceLow;

  int         submitCnt;
  int         rejectCnt;
  int         bothCnt;
  logic       prevSubmit;
  logic [4:0] capP [6];
  logic [2:0] afterCnt;
  logic [4:0] afterP0;

  keypad_password_entry #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .MIN_LEN        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: the pressed key pulls its row low only while its column is driven.
  always_comb begin
    if (bounceLow)
      bus.key_row = 4'b1101;
    else if (keyDown && !bus.key_col[keyC])
      bus.key_row = ~(4'b0001 << keyR);
    else
      bus.key_row = 4'hF;
  end

  always @(negedge clk) begin
    if (bus.submit) begin
      submitCnt++;
      capP[0] <= bus.p0; capP[1] <= bus.p1; capP[2] <= bus.p2;
      capP[3] <= bus.p3; capP[4] <= bus.p4; capP[5] <= bus.p5;
    end
    if (prevSubmit) begin
      afterCnt <= bus.digit_cnt;
      afterP0  <= bus.p0;
    end
    if (bus.reject) rejectCnt++;
    if (bus.submit && bus.reject) bothCnt++;
    prevSubmit <= bus.submit;
  end

  task automatic pressKey(input logic [1:0] r, input logic [1:0] c);
    keyR = r;
    keyC = c;
    keyDown = 1'b1;
    repeat (100) @(posedge clk);
    keyDown = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pressDigit(input int d);
    case (d)
      0: pressKey(2'd3, 2'd1);
      1: pressKey(2'd0, 2'd0);
      2: pressKey(2'd0, 2'd1);
      3: pressKey(2'd0, 2'd2);
      4: pressKey(2'd1, 2'd0);
      5: pressKey(2'd1, 2'd1);
      6: pressKey(2'd1, 2'd2);
      7: pressKey(2'd2, 2'd0);
      8: pressKey(2'd2, 2'd1);
      default: pressKey(2'd2, 2'd2);
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.key_col !== 4'b1110) begin errors++; $display("[TB] FAIL reset_key_col got=%b exp=1110", bus.key_col); end
    checks++; if (bus.digit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_digit_cnt got=%0d exp=0", bus.digit_cnt); end
    checks++; if (bus.p0 !== 5'h1F || bus.p5 !== 5'h1F) begin errors++; $display("[TB] FAIL reset_fields got p0=%h p5=%h exp=1f", bus.p0, bus.p5); end
    checks++; if (bus.show_digits !== 1'b0) begin errors++; $display("[TB] FAIL reset_show got=%b exp=0", bus.show_digits); end
    checks++; if (bus.submit !== 1'b0 || bus.reject !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got submit=%b reject=%b exp=0/0", bus.submit, bus.reject); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_key;
    pressDigit(5);
    checks++; if (bus.p0 !== 5'd5) begin errors++; $display("[TB] FAIL single_p0 got=%h exp=05", bus.p0); end
    checks++; if (bus.digit_cnt !== 3'd1) begin errors++; $display("[TB] FAIL single_cnt got=%0d exp=1 (one event only)", bus.digit_cnt); end
    checks++; if (bus.p1 !== 5'h1F || bus.p5 !== 5'h1F) begin errors++; $display("[TB] FAIL single_empty got p1=%h p5=%h exp=1f", bus.p1, bus.p5); end
  endtask

  task automatic test_bounce;
    bounceLow = 1'b1; repeat (8) @(posedge clk);
    bounceLow = 1'b0; repeat (8) @(posedge clk);
    bounceLow = 1'b1; repeat (8) @(posedge clk);
    bounceLow = 1'b0; repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.digit_cnt !== 3'd1) begin errors++; $display("[TB] FAIL bounce_cnt got=%0d exp=1", bus.digit_cnt); end
    checks++; if (bus.p0 !== 5'd5 || bus.p1 !== 5'h1F) begin errors++; $display("[TB] FAIL bounce_fields got p0=%h p1=%h exp=05/1f", bus.p0, bus.p1); end
    pressKey(2'd1, 2'd3);
    checks++; if (bus.digit_cnt !== 3'd0 || bus.p0 !== 5'h1F) begin errors++; $display("[TB] FAIL clear got cnt=%0d p0=%h exp=0/1f", bus.digit_cnt, bus.p0); end
  endtask

  task automatic test_full;
    for (int d = 1; d <= 7; d++) pressDigit(d);
    checks++; if (bus.digit_cnt !== 3'd6) begin errors++; $display("[TB] FAIL full_cnt got=%0d exp=6", bus.digit_cnt); end
    checks++; if ({bus.p0, bus.p1, bus.p2} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("[TB] FAIL full_p012 got=%h %h %h exp=01 02 03", bus.p0, bus.p1, bus.p2); end
    checks++; if ({bus.p3, bus.p4, bus.p5} !== {5'd4, 5'd5, 5'd6}) begin errors++; $display("[TB] FAIL full_p345 got=%h %h %h exp=04 05 06", bus.p3, bus.p4, bus.p5); end
    pressKey(2'd3, 2'd0);
    pressKey(2'd3, 2'd3);
    checks++; if (bus.digit_cnt !== 3'd6 || bus.p5 !== 5'd6) begin errors++; $display("[TB] FAIL ignore_DE got cnt=%0d p5=%h exp=6/06", bus.digit_cnt, bus.p5); end
    pressKey(2'd1, 2'd3);
  endtask

  task automatic test_backspace_reject;
    pressDigit(1); pressDigit(2); pressDigit(3);
    pressKey(2'd0, 2'd3);
    pressDigit(9);
    checks++; if ({bus.p0, bus.p1, bus.p2} !== {5'd1, 5'd2, 5'd9}) begin errors++; $display("[TB] FAIL bksp_fields got=%h %h %h exp=01 02 09", bus.p0, bus.p1, bus.p2); end
    checks++; if (bus.digit_cnt !== 3'd3 || bus.p3 !== 5'h1F) begin errors++; $display("[TB] FAIL bksp_cnt got cnt=%0d p3=%h exp=3/1f", bus.digit_cnt, bus.p3); end
    rejectCnt = 0; submitCnt = 0;
    pressKey(2'd2, 2'd3);
    checks++; if (rejectCnt !== 1) begin errors++; $display("[TB] FAIL reject_pulse got=%0d cycles exp=1", rejectCnt); end
    checks++; if (submitCnt !== 0) begin errors++; $display("[TB] FAIL reject_no_submit got=%0d exp=0", submitCnt); end
    checks++; if (bus.digit_cnt !== 3'd3 || bus.p2 !== 5'd9) begin errors++; $display("[TB] FAIL reject_keep got cnt=%0d p2=%h exp=3/09", bus.digit_cnt, bus.p2); end
    pressKey(2'd1, 2'd3);
  endtask

  task automatic test_submit_show;
    pressDigit(4); pressDigit(3); pressDigit(2); pressDigit(1);
    rejectCnt = 0; submitCnt = 0;
    pressKey(2'd2, 2'd3);
    checks++; if (submitCnt !== 1) begin errors++; $display("[TB] FAIL submit_pulse got=%0d cycles exp=1", submitCnt); end
    checks++; if (rejectCnt !== 0) begin errors++; $display("[TB] FAIL submit_no_reject got=%0d exp=0", rejectCnt); end
    checks++; if ({capP[0], capP[1], capP[2], capP[3]} !== {5'd4, 5'd3, 5'd2, 5'd1}) begin errors++; $display("[TB] FAIL submit_fields got=%h %h %h %h exp=04 03 02 01", capP[0], capP[1], capP[2], capP[3]); end
    checks++; if (capP[4] !== 5'h1F) begin errors++; $display("[TB] FAIL submit_p4 got=%h exp=1f", capP[4]); end
    checks++; if (afterCnt !== 3'd0 || afterP0 !== 5'h1F) begin errors++; $display("[TB] FAIL submit_clear got cnt=%0d p0=%h exp=0/1f", afterCnt, afterP0); end
    pressKey(2'd3, 2'd2);
    checks++; if (bus.show_digits !== 1'b1) begin errors++; $display("[TB] FAIL show_on got=%b exp=1", bus.show_digits); end
    pressKey(2'd3, 2'd2);
    checks++; if (bus.show_digits !== 1'b0) begin errors++; $display("[TB] FAIL show_off got=%b exp=0", bus.show_digits); end
  endtask

  task automatic test_lock;
    bus.lock = 1'b1;
    pressDigit(7);
    checks++; if (bus.digit_cnt !== 3'd0 || bus.p0 !== 5'h1F) begin errors++; $display("[TB] FAIL lock got cnt=%0d p0=%h exp=0/1f", bus.digit_cnt, bus.p0); end
    bus.lock = 1'b0;
  endtask

  task automatic test_reset_mid;
    int waitCnt;
    pressDigit(8);
    pressKey(2'd3, 2'd2);
    checks++; if (bus.digit_cnt !== 3'd1 || bus.show_digits !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset got cnt=%0d show=%b exp=1/1", bus.digit_cnt, bus.show_digits); end
    keyR = 2'd2; keyC = 2'd1; keyDown = 1'b1;
    waitCnt = 0;
    while (bus.key_col[1] !== 1'b0 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++; if (waitCnt >= 200) begin errors++; $display("[TB] FAIL col_wait got timeout exp=col1 driven"); end
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.key_col !== 4'b1110) begin errors++; $display("[TB] FAIL async_key_col got=%b exp=1110", bus.key_col); end
    checks++; if (bus.digit_cnt !== 3'd0 || bus.p0 !== 5'h1F) begin errors++; $display("[TB] FAIL async_fields got cnt=%0d p0=%h exp=0/1f", bus.digit_cnt, bus.p0); end
    checks++; if (bus.show_digits !== 1'b0 || bus.submit !== 1'b0 || bus.reject !== 1'b0) begin errors++; $display("[TB] FAIL async_flags got show=%b submit=%b reject=%b exp=0", bus.show_digits, bus.submit, bus.reject); end
    keyDown = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    keyDown = 1'b0; keyR = 2'd0; keyC = 2'd0; bounceLow = 1'b0;
    bus.lock = 1'b0;
    submitCnt = 0; rejectCnt = 0; bothCnt = 0; prevSubmit = 1'b0;
    afterCnt = 3'd7; afterP0 = 5'd0;
    for (int i = 0; i < 6; i++) capP[i] = 5'd0;
    test_reset;
    test_single_key;
    test_bounce;
    test_full;
    test_backspace_reject;
    test_submit_show;
    test_lock;
    test_reset_mid;
    checks++; if (bothCnt !== 0) begin errors++; $display("[TB] FAIL pulse_overlap got=%0d exp=0", bothCnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
